// File: rtl/stage_complete.sv
// stage_complete: completion buffer that queues execute results oldest-first and drains up to CDB_W per cycle.
// Optional same-cycle input-to-CDB bypass is enabled by defining COMPLETE_BYPASS_EN.
module stage_complete #(
    parameter int unsigned N         = 3,
    parameter int unsigned CDB_W     = 2,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ROB_IDX_W = 5,
    parameter int unsigned TAG_W     = 6,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [N-1:0]                 in_valid,
    input  logic [N*ROB_IDX_W-1:0]       in_rob_idx,
    input  logic [N*TAG_W-1:0]           in_dest_tag,
    input  logic [N-1:0]                 in_has_dest,
    input  logic [N*DATA_W-1:0]          in_value,
    output logic                         in_ready,
    output logic [CDB_W-1:0]             cdb_valid,
    output logic [CDB_W*ROB_IDX_W-1:0]   cdb_rob_idx,
    output logic [CDB_W*TAG_W-1:0]       cdb_dest_tag,
    output logic [CDB_W-1:0]             cdb_has_dest,
    output logic [CDB_W*DATA_W-1:0]      cdb_value,
    output logic [$clog2(DEPTH):0]       occupancy,
    output logic                         overflow_err
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [TAG_W-1:0]     dest_tag;
        logic                 has_dest;
        logic [DATA_W-1:0]    value;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          ovf_q, ovf_d;

    entry_t        lane_e  [N];
    entry_t        slot_e  [CDB_W];
    logic [N-1:0]  byp_lane;
    logic [N-1:0]  wr_lane;
    logic [PW-1:0] wr_addr [N];
    logic [OW-1:0] pops;
    logic [OW-1:0] free;
    logic [OW-1:0] acc;
    logic          drop;

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            lane_e[i].rob_idx  = in_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
            lane_e[i].dest_tag = in_dest_tag[i*TAG_W +: TAG_W];
            lane_e[i].has_dest = in_has_dest[i];
            lane_e[i].value    = in_value[i*DATA_W +: DATA_W];
        end
    end

    // Slot j shows FIFO entry head+j; unfilled slots optionally take this cycle's lanes.
    always_comb begin
        pops      = (occ_q > OW'(CDB_W)) ? OW'(CDB_W) : occ_q;
        cdb_valid = '0;
        byp_lane  = '0;
        for (int unsigned j = 0; j < CDB_W; j++) begin
            slot_e[j] = '0;
            if (OW'(j) < occ_q) begin
                cdb_valid[j] = 1'b1;
                slot_e[j]    = mem_q[head_q + PW'(j)];
            end
        end
`ifdef COMPLETE_BYPASS_EN
        for (int unsigned j = 0; j < CDB_W; j++) begin : g_byp
            logic found;
            found = 1'b0;
            if (!cdb_valid[j] && !flush && reset) begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (!found && in_valid[i] && !byp_lane[i]) begin
                        found        = 1'b1;
                        byp_lane[i]  = 1'b1;
                        cdb_valid[j] = 1'b1;
                        slot_e[j]    = lane_e[i];
                    end
                end
            end
        end
`endif
    end

    always_comb begin
        cdb_rob_idx  = '0;
        cdb_dest_tag = '0;
        cdb_has_dest = '0;
        cdb_value    = '0;
        for (int unsigned j = 0; j < CDB_W; j++) begin
            cdb_rob_idx[j*ROB_IDX_W +: ROB_IDX_W] = slot_e[j].rob_idx;
            cdb_dest_tag[j*TAG_W +: TAG_W]        = slot_e[j].dest_tag;
            cdb_has_dest[j]                       = slot_e[j].has_dest;
            cdb_value[j*DATA_W +: DATA_W]         = slot_e[j].value;
        end
    end

    // Free space counts this cycle's pops; lowest-index lanes win when space runs out.
    always_comb begin
        free    = OW'(DEPTH) - occ_q + pops;
        acc     = '0;
        drop    = 1'b0;
        wr_lane = '0;
        for (int unsigned i = 0; i < N; i++) begin
            wr_addr[i] = tail_q + acc[PW-1:0];
            if (in_valid[i] && !byp_lane[i] && !flush) begin
                if (acc < free) begin
                    wr_lane[i] = 1'b1;
                    acc        = acc + 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_comb begin
        head_d = head_q + pops[PW-1:0];
        tail_d = tail_q + acc[PW-1:0];
        occ_d  = occ_q - pops + acc;
        ovf_d  = ovf_q | drop;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
            ovf_d  = ovf_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < N; i++) begin
            if (wr_lane[i]) begin
                mem_q[wr_addr[i]] <= lane_e[i];
            end
        end
    end

    assign in_ready     = (occ_q <= OW'(DEPTH - N));
    assign occupancy    = occ_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_stage_complete.sv
// tb_stage_complete: randomized bench comparing stage_complete against a queue-based model of the buffer.
module tb_stage_complete;
    localparam int unsigned N     = 3;
    localparam int unsigned CDB_W = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned RW    = 5;
    localparam int unsigned TW    = 6;
    localparam int unsigned DW    = 32;

    typedef struct packed {
        logic [RW-1:0] rob;
        logic [TW-1:0] tag;
        logic          has;
        logic [DW-1:0] val;
    } ent_t;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  flush;
    logic [N-1:0]          in_valid;
    logic [N*RW-1:0]       in_rob_idx;
    logic [N*TW-1:0]       in_dest_tag;
    logic [N-1:0]          in_has_dest;
    logic [N*DW-1:0]       in_value;
    logic                  in_ready;
    logic [CDB_W-1:0]      cdb_valid;
    logic [CDB_W*RW-1:0]   cdb_rob_idx;
    logic [CDB_W*TW-1:0]   cdb_dest_tag;
    logic [CDB_W-1:0]      cdb_has_dest;
    logic [CDB_W*DW-1:0]   cdb_value;
    logic [$clog2(DEPTH):0] occupancy;
    logic                  overflow_err;

    stage_complete #(
        .N(N), .CDB_W(CDB_W), .DEPTH(DEPTH), .ROB_IDX_W(RW), .TAG_W(TW), .DATA_W(DW)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_rob_idx(in_rob_idx), .in_dest_tag(in_dest_tag),
        .in_has_dest(in_has_dest), .in_value(in_value), .in_ready(in_ready),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_dest_tag(cdb_dest_tag),
        .cdb_has_dest(cdb_has_dest), .cdb_value(cdb_value),
        .occupancy(occupancy), .overflow_err(overflow_err)
    );

    always #5 clock = ~clock;

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    ent_t         q[$];
    logic         m_ovf;
    logic [N-1:0] byp_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t lane(input int unsigned i);
        ent_t e;
        e.rob = in_rob_idx[i*RW +: RW];
        e.tag = in_dest_tag[i*TW +: TW];
        e.has = in_has_dest[i];
        e.val = in_value[i*DW +: DW];
        return e;
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic fl, input logic [N*RW-1:0] robs);
        in_valid   = v;
        flush      = fl;
        in_rob_idx = robs;
        for (int unsigned i = 0; i < N; i++) begin
            in_dest_tag[i*TW +: TW] = TW'($urandom);
            in_has_dest[i]          = 1'($urandom);
            in_value[i*DW +: DW]    = $urandom;
        end
    endtask

    task automatic compare();
        ent_t             exp_e [CDB_W];
        logic [CDB_W-1:0] exp_v;
        exp_v = '0;
        byp_m = '0;
        for (int unsigned j = 0; j < CDB_W; j++) begin
            exp_e[j] = '0;
            if (j < q.size()) begin
                exp_v[j] = 1'b1;
                exp_e[j] = q[j];
            end
        end
`ifdef COMPLETE_BYPASS_EN
        if (!flush) begin
            int unsigned nxt;
            nxt = (q.size() < CDB_W) ? q.size() : CDB_W;
            for (int unsigned i = 0; i < N; i++) begin
                if (in_valid[i] && nxt < CDB_W) begin
                    exp_v[nxt] = 1'b1;
                    exp_e[nxt] = lane(i);
                    byp_m[i]   = 1'b1;
                    nxt++;
                end
            end
        end
`endif
        check("occupancy", 64'(occupancy), 64'(q.size()));
        check("in_ready", 64'(in_ready), 64'(q.size() + N <= DEPTH));
        check("overflow_err", 64'(overflow_err), 64'(m_ovf));
        for (int unsigned j = 0; j < CDB_W; j++) begin
            check("cdb_valid", 64'(cdb_valid[j]), 64'(exp_v[j]));
            if (exp_v[j]) begin
                check("cdb_entry",
                      64'({cdb_rob_idx[j*RW +: RW], cdb_dest_tag[j*TW +: TW],
                           cdb_has_dest[j], cdb_value[j*DW +: DW]}),
                      64'(exp_e[j]));
            end
        end
    endtask

    task automatic update();
        int unsigned pops;
        pops = (q.size() < CDB_W) ? q.size() : CDB_W;
        repeat (pops) void'(q.pop_front());
        if (flush) begin
            q.delete();
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (in_valid[i] && !byp_m[i]) begin
                    if (q.size() < DEPTH) q.push_back(lane(i));
                    else m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic fl, input logic [N*RW-1:0] robs);
        drive(v, fl, robs);
        @(negedge clock);
        compare();
        @(posedge clock);
        update();
        #1;
    endtask

    function automatic logic [N*RW-1:0] rrob();
        return (N*RW)'($urandom);
    endfunction

    task automatic check_cleared();
        check("rst cdb_valid", 64'(cdb_valid), 64'(0));
        check("rst occupancy", 64'(occupancy), 64'(0));
        check("rst in_ready", 64'(in_ready), 64'(1));
        check("rst overflow_err", 64'(overflow_err), 64'(0));
        check("rst cdb_value", 64'(cdb_value), 64'(0));
    endtask

    initial begin
        reset = 1'b0;
        m_ovf = 1'b0;
        byp_m = '0;
        drive('0, 1'b0, '0);
        repeat (4) begin
            drive(N'($urandom), 1'($urandom), rrob());
            @(negedge clock);
            check_cleared();
        end
        drive('0, 1'b0, '0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // two sparse lanes, then drain
        step(3'b101, 1'b0, {5'd7, 5'd0, 5'd3});
        step('0, 1'b0, rrob());
        step('0, 1'b0, rrob());

        // three full bursts through the narrower CDB, wrapping the pointers
        repeat (3) step(3'b111, 1'b0, rrob());
        repeat (6) step('0, 1'b0, rrob());

        // push past full: occupancy climbs to DEPTH, then lanes get dropped
        repeat (7) step(3'b111, 1'b0, rrob());
        repeat (6) step('0, 1'b0, rrob());

        // flush with live entries and valid inputs
        step(3'b111, 1'b0, rrob());
        step(3'b111, 1'b0, rrob());
        step(3'b011, 1'b1, rrob());
        step('0, 1'b0, rrob());
        step('0, 1'b0, rrob());

        for (int unsigned n = 0; n < 1500; n++) begin
            logic [N-1:0] v;
            v = N'($urandom);
            if ($urandom_range(0, 3) == 0) v = '0;
            step(v, ($urandom_range(0, 19) == 0), rrob());
            if (n == 700) begin
                drive('0, 1'b0, '0);
                #2 reset = 1'b0;
                #1 check_cleared();
                q.delete();
                m_ovf = 1'b0;
                @(negedge clock);
                reset = 1'b1;
                @(posedge clock);
                #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
